// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator entry controller:
// FSM states, key codes, operator and display-select codes.
package calc_pkg;

  typedef enum logic [2:0] {
    S_AUG  = 3'd0,
    S_ADD  = 3'd1,
    S_EXEC = 3'd2,
    S_DONE = 3'd3
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [1:0] DISP_AUG   = 2'b00;
  localparam logic [1:0] DISP_ADDEN = 2'b01;
  localparam logic [1:0] DISP_RES   = 2'b10;

  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    case (key)
      KEY_SUB: key_to_op = OP_SUB;
      KEY_MUL: key_to_op = OP_MUL;
      default: key_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational add/sub/mul on the two operands, result as sign/magnitude.
module calc_alu
  import calc_pkg::*;
#(
  parameter int OPW  = 7,
  parameter int RESW = 14
) (
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [1:0]      op,
  output logic [RESW-1:0] mag,
  output logic            neg
);

  logic [RESW-1:0] a_ext, b_ext;

  assign a_ext = RESW'(a);
  assign b_ext = RESW'(b);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (op)
      OP_ADD: mag = a_ext + b_ext;
      // Subtraction is reported as magnitude plus sign rather than two's complement.
      OP_SUB: begin
        if (a_ext >= b_ext) begin
          mag = a_ext - b_ext;
        end else begin
          mag = b_ext - a_ext;
          neg = 1'b1;
        end
      end
      OP_MUL: mag = a_ext * b_ext;
      default: mag = '0;
    endcase
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry sequencer: multi-digit operand entry, operator latch,
// single-cycle execute, and display select for the 7-seg mux.
//   state  | meaning
//   S_AUG  | entering augend digits
//   S_ADD  | operator latched, entering addend digits
//   S_EXEC | one cycle: register ALU result
//   S_DONE | showing result; a digit starts a new augend
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int OPW        = 7,
  parameter int RESW       = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  output logic [OPW-1:0]  aug,
  output logic [OPW-1:0]  adden,
  output logic [1:0]      op,
  output logic [RESW-1:0] result_mag,
  output logic            result_neg,
  output logic            result_valid,
  output logic [1:0]      disp_sel,
  output logic [2:0]      state_dbg
);

  localparam int DCW = $clog2(MAX_DIGITS + 1);

  state_t          state;
  logic [DCW-1:0]  dcnt;
  logic [RESW-1:0] alu_mag;
  logic            alu_neg;
  logic            is_digit, is_op, dig_ok;
  logic [OPW-1:0]  digit;

  assign is_digit  = (key_code <= 4'd9);
  assign is_op     = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);
  assign dig_ok    = (dcnt < DCW'(MAX_DIGITS));
  assign digit     = OPW'(key_code);
  assign state_dbg = state;

  calc_alu #(.OPW(OPW), .RESW(RESW)) u_alu (
    .a   (aug),
    .b   (adden),
    .op  (op),
    .mag (alu_mag),
    .neg (alu_neg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_AUG;
      dcnt         <= '0;
      aug          <= '0;
      adden        <= '0;
      op           <= OP_ADD;
      result_mag   <= '0;
      result_neg   <= 1'b0;
      result_valid <= 1'b0;
      disp_sel     <= DISP_AUG;
    end else begin
      result_valid <= 1'b0;
      // Clear wins in every state, including over the EXEC result write.
      if (key_valid && key_code == KEY_CLR) begin
        state      <= S_AUG;
        dcnt       <= '0;
        aug        <= '0;
        adden      <= '0;
        op         <= OP_ADD;
        result_mag <= '0;
        result_neg <= 1'b0;
        disp_sel   <= DISP_AUG;
      end else begin
        case (state)
          S_AUG: begin
            if (key_valid && is_digit && dig_ok) begin
              aug  <= OPW'(aug * OPW'(10)) + digit;
              dcnt <= dcnt + DCW'(1);
            end else if (key_valid && is_op) begin
              op       <= key_to_op(key_code);
              dcnt     <= '0;
              state    <= S_ADD;
              disp_sel <= DISP_ADDEN;
            end
          end
          S_ADD: begin
            if (key_valid && is_digit && dig_ok) begin
              adden <= OPW'(adden * OPW'(10)) + digit;
              dcnt  <= dcnt + DCW'(1);
            end else if (key_valid && is_op && dcnt == '0) begin
              op <= key_to_op(key_code);
            end else if (key_valid && key_code == KEY_EQ) begin
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            result_mag   <= alu_mag;
            result_neg   <= alu_neg;
            result_valid <= 1'b1;
            state        <= S_DONE;
            disp_sel     <= DISP_RES;
          end
          S_DONE: begin
            if (key_valid && is_digit) begin
              aug      <= digit;
              adden    <= '0;
              dcnt     <= DCW'(1);
              state    <= S_AUG;
              disp_sel <= DISP_AUG;
            end
          end
          default: begin
            state    <= S_AUG;
            disp_sel <= DISP_AUG;
          end
        endcase
      end
    end
  end

endmodule
